// File: rtl/branch_predictor.sv
// Dynamic branch predictor: BTB plus 2-bit PHT with optional gshare history.
// IF gets a same-cycle next-PC guess; EX resolution trains tables and flags mispredictions.
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int XLEN    = 32,
  parameter int HIST_W  = 0,
  parameter int CNT_W   = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                if_valid,
  input  logic [XLEN-1:0]                     if_pc,
  output logic                                pred_hit,
  output logic                                pred_taken,
  output logic [XLEN-1:0]                     pred_npc,
  output logic [((HIST_W > 0) ? HIST_W : 1)-1:0] pred_ghr,
  input  logic                                upd_valid,
  input  logic [XLEN-1:0]                     upd_pc,
  input  logic                                upd_is_branch,
  input  logic                                upd_is_jump,
  input  logic                                upd_taken,
  input  logic [XLEN-1:0]                     upd_target,
  input  logic                                upd_pred_taken,
  input  logic [XLEN-1:0]                     upd_pred_npc,
  input  logic [((HIST_W > 0) ? HIST_W : 1)-1:0] upd_ghr,
  input  logic                                inv_all,
  output logic                                mispredict,
  output logic [CNT_W-1:0]                    br_cnt,
  output logic [CNT_W-1:0]                    miss_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam int GW    = (HIST_W > 0) ? HIST_W : 1;

  logic             btb_valid [ENTRIES];
  logic [TAG_W-1:0] btb_tag   [ENTRIES];
  logic [XLEN-1:0]  btb_tgt   [ENTRIES];
  logic             btb_jmp   [ENTRIES];
  logic [1:0]       pht       [ENTRIES];
  logic [GW-1:0]    ghr;

  logic [IDX_W-1:0] lk_idx, lk_pidx, up_idx, up_pidx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_ctrl;
  logic             unused_ok;

  // History is folded into the PHT index only in gshare mode.
  function automatic logic [IDX_W-1:0] hist_ext(input logic [GW-1:0] h);
    if (HIST_W == 0) return '0;
    return IDX_W'(h);
  endfunction

  assign lk_idx  = if_pc[IDX_W+1:2];
  assign lk_tag  = if_pc[XLEN-1:IDX_W+2];
  assign lk_pidx = lk_idx ^ hist_ext(ghr);
  assign up_idx  = upd_pc[IDX_W+1:2];
  assign up_tag  = upd_pc[XLEN-1:IDX_W+2];
  assign up_pidx = up_idx ^ hist_ext(upd_ghr);
  assign up_ctrl = upd_is_branch | upd_is_jump;

  assign unused_ok = ^{if_pc[1:0], upd_pc[1:0]};

  always_comb begin
    pred_hit   = if_valid & btb_valid[lk_idx] & (btb_tag[lk_idx] == lk_tag);
    pred_taken = pred_hit & (btb_jmp[lk_idx] | pht[lk_pidx][1]);
    pred_npc   = pred_taken ? btb_tgt[lk_idx] : (if_pc + XLEN'(4));
    pred_ghr   = ghr;
  end

  assign mispredict = upd_valid & up_ctrl &
                      ((upd_pred_taken != upd_taken) |
                       (upd_taken & (upd_pred_npc != upd_target)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
        pht[i]       <= 2'b01;
      end
      ghr      <= '0;
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else begin
      if (upd_valid && upd_is_branch) begin
        if (upd_taken && pht[up_pidx] != 2'b11)
          pht[up_pidx] <= pht[up_pidx] + 2'b01;
        else if (!upd_taken && pht[up_pidx] != 2'b00)
          pht[up_pidx] <= pht[up_pidx] - 2'b01;
        if (HIST_W > 0)
          ghr <= GW'({ghr, upd_taken});
      end
      if (upd_valid && up_ctrl && upd_taken)
        btb_valid[up_idx] <= 1'b1;
      if (upd_valid && up_ctrl)
        br_cnt <= br_cnt + CNT_W'(1);
      if (mispredict)
        miss_cnt <= miss_cnt + CNT_W'(1);
      // Invalidation is placed last so it overrides a same-cycle BTB fill and history shift.
      if (inv_all) begin
        for (int i = 0; i < ENTRIES; i++)
          btb_valid[i] <= 1'b0;
        ghr <= '0;
      end
    end
  end

  // Tag/target/type are qualified by the valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    if (upd_valid && up_ctrl && upd_taken) begin
      btb_tag[up_idx] <= up_tag;
      btb_tgt[up_idx] <= upd_target;
      btb_jmp[up_idx] <= upd_is_jump;
    end
  end

endmodule
